// File: rtl/inst_fetch_ctrl_if.sv
// Bundle of every signal between the fetch sequencer and its neighbours:
// instruction memory, decode, branch unit and the execute stage.
interface inst_fetch_ctrl_if;
    logic        start;
    logic        mem_init;
    logic [31:0] mem_pc;
    logic [31:0] mem_instr;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        conv_done;
    logic        conv_wait;
    logic        halted;

    modport master (
        input  start, mem_instr, instr_ready, redirect, redirect_pc, conv_done,
        output mem_init, mem_pc, instr, instr_pc, instr_valid, conv_wait, halted
    );

    modport slave (
        output start, mem_instr, instr_ready, redirect, redirect_pc, conv_done,
        input  mem_init, mem_pc, instr, instr_pc, instr_valid, conv_wait, halted
    );
endinterface

// File: rtl/inst_fetch_ctrl.sv
// Fetch sequencer: pulses memory init, walks the PC, and feeds a registered
// valid/ready stage to decode with redirect, convolution stall and halt.
module inst_fetch_ctrl #(
    parameter int unsigned MEM_BYTES     = 32,
    parameter int unsigned INIT_CYCLES   = 2,
    parameter bit          WRAP          = 1'b0,
    parameter logic [6:0]  CUSTOM_OPCODE = 7'b0001011
) (
    input  logic               clk,
    input  logic               reset,
    inst_fetch_ctrl_if.master  bus
);
    typedef enum logic [2:0] {IDLE, INIT, FETCH, CONV_WAIT, HALT} state_t;

    localparam logic [31:0] LAST_PC   = 32'(MEM_BYTES - 4);
    localparam logic [31:0] MEM_TOP   = 32'(MEM_BYTES);
    localparam logic [31:0] INIT_LOAD = 32'(INIT_CYCLES);

    state_t      state;
    logic [31:0] cnt;
    logic        last;

    logic        accept;
    logic        at_end;
    logic        is_custom;
    logic        redir_oob;
    logic        redir_live;
    logic        can_restart;
    logic [31:0] redir_target;

    assign accept       = bus.instr_valid & bus.instr_ready;
    assign at_end       = (bus.mem_pc == LAST_PC);
    assign is_custom    = (bus.instr[6:0] == CUSTOM_OPCODE);
    assign redir_oob    = (bus.redirect_pc >= MEM_TOP);
    assign redir_target = {bus.redirect_pc[31:2], 2'b00};
    assign redir_live   = bus.redirect && ((state == FETCH) || (state == CONV_WAIT));
    assign can_restart  = bus.start && ((state == IDLE) || (state == HALT));

    // NOTE: non-blocking assignments so every branch sees pre-edge register values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            cnt             <= INIT_LOAD;
            last            <= 1'b0;
            bus.mem_init    <= 1'b0;
            bus.mem_pc      <= '0;
            bus.instr       <= '0;
            bus.instr_pc    <= '0;
            bus.instr_valid <= 1'b0;
            bus.conv_wait   <= 1'b0;
            bus.halted      <= 1'b0;
        end else if (can_restart) begin
            state        <= INIT;
            cnt          <= INIT_LOAD;
            last         <= 1'b0;
            bus.mem_init <= 1'b1;
            bus.mem_pc   <= '0;
            bus.halted   <= 1'b0;
        end else if (redir_live) begin
            // Redirect outranks accept, conv_done and load in the same cycle.
            bus.instr_valid <= 1'b0;
            bus.conv_wait   <= 1'b0;
            last            <= 1'b0;
            if (redir_oob) begin
                state      <= HALT;
                bus.halted <= 1'b1;
            end else begin
                state      <= FETCH;
                bus.mem_pc <= redir_target;
            end
        end else begin
            case (state)
                IDLE: begin
                    cnt        <= INIT_LOAD;
                    bus.mem_pc <= '0;
                end
                INIT: begin
                    if (cnt <= 32'd1) begin
                        state        <= FETCH;
                        bus.mem_init <= 1'b0;
                    end else begin
                        cnt <= cnt - 32'd1;
                    end
                end
                FETCH: begin
                    if (accept && is_custom) begin
                        state           <= CONV_WAIT;
                        bus.conv_wait   <= 1'b1;
                        bus.instr_valid <= 1'b0;
                    end else if (accept && last) begin
                        state           <= HALT;
                        bus.halted      <= 1'b1;
                        bus.instr_valid <= 1'b0;
                    end else if ((!bus.instr_valid || accept) && !last) begin
                        bus.instr       <= bus.mem_instr;
                        bus.instr_pc    <= bus.mem_pc;
                        bus.instr_valid <= 1'b1;
                        if (!at_end) begin
                            bus.mem_pc <= bus.mem_pc + 32'd4;
                        end else if (WRAP) begin
                            bus.mem_pc <= '0;
                        end else begin
                            last <= 1'b1;
                        end
                    end
                end
                CONV_WAIT: begin
                    // mem_pc already points past the convolution word.
                    if (bus.conv_done) begin
                        bus.conv_wait <= 1'b0;
                        if (last) begin
                            state      <= HALT;
                            bus.halted <= 1'b1;
                        end else begin
                            state <= FETCH;
                        end
                    end
                end
                HALT: begin
                    bus.halted <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Scoreboard bench for inst_fetch_ctrl: directed stimulus pushes expected
// instructions, negedge monitors pop and compare on every accept.
module tb_inst_fetch_ctrl;
    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
    } exp_t;

    logic clk;
    logic reset;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    exp_t mq[$];
    exp_t wq[$];

    logic [31:0] rom [8] = '{
        32'h010C0E0B, 32'h413903B3, 32'h035A02B3, 32'h00B50533,
        32'h00100093, 32'h00208113, 32'h40315233, 32'h00008067
    };

    inst_fetch_ctrl_if m_if ();
    inst_fetch_ctrl_if w_if ();

    inst_fetch_ctrl #(.MEM_BYTES(32), .INIT_CYCLES(2), .WRAP(1'b0)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (m_if)
    );

    inst_fetch_ctrl #(.MEM_BYTES(32), .INIT_CYCLES(2), .WRAP(1'b1)) u_wrap (
        .clk   (clk),
        .reset (reset),
        .bus   (w_if)
    );

    assign m_if.mem_instr = rom[m_if.mem_pc[4:2]];
    assign w_if.mem_instr = rom[w_if.mem_pc[4:2]];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t mk(input logic [31:0] pc);
        exp_t e;
        e.pc   = pc;
        e.word = rom[pc[4:2]];
        return e;
    endfunction

    task automatic push_main(input logic [31:0] pc);
        mq.push_back(mk(pc));
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_mem_init"},    32'(m_if.mem_init),    32'd0);
        check({tag, "_mem_pc"},      m_if.mem_pc,           32'd0);
        check({tag, "_instr"},       m_if.instr,            32'd0);
        check({tag, "_instr_pc"},    m_if.instr_pc,         32'd0);
        check({tag, "_instr_valid"}, 32'(m_if.instr_valid), 32'd0);
        check({tag, "_conv_wait"},   32'(m_if.conv_wait),   32'd0);
        check({tag, "_halted"},      32'(m_if.halted),      32'd0);
    endtask

    // Main-instance monitor: every accept must match the head of the queue.
    always @(negedge clk) begin : mon_main
        exp_t e;
        if (m_if.instr_valid && m_if.instr_ready) begin
            if (mq.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL main_unexpected: instr_pc=0x%08h presented, none expected", m_if.instr_pc);
            end else begin
                e = mq.pop_front();
                check("main_instr_pc", m_if.instr_pc, e.pc);
                check("main_instr",    m_if.instr,    e.word);
            end
        end
    end

    logic [31:0] w_last_pc  = 32'd0;
    int          w_last_cyc = 0;

    always @(negedge clk) begin : mon_wrap
        exp_t e;
        if (w_if.instr_valid && w_if.instr_ready) begin
            if (wq.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL wrap_unexpected: instr_pc=0x%08h presented, none expected", w_if.instr_pc);
            end else begin
                e = wq.pop_front();
                check("wrap_instr_pc", w_if.instr_pc, e.pc);
                check("wrap_instr",    w_if.instr,    e.word);
                if (e.pc == 32'd0 && w_last_pc == 32'd28)
                    check("wrap_no_gap", 32'(cyc - w_last_cyc), 32'd1);
                w_last_pc  = e.pc;
                w_last_cyc = cyc;
            end
        end
    end

    initial begin
        reset              = 1'b0;
        m_if.start         = 1'b0;
        m_if.instr_ready   = 1'b1;
        m_if.redirect      = 1'b0;
        m_if.redirect_pc   = '0;
        m_if.conv_done     = 1'b0;
        w_if.start         = 1'b0;
        w_if.instr_ready   = 1'b1;
        w_if.redirect      = 1'b0;
        w_if.redirect_pc   = '0;
        w_if.conv_done     = 1'b1;

        repeat (2) tick();
        check_reset_state("rst");
        reset = 1'b1;
        tick();

        // Default program: init pulse, custom-0 at 0, stall, then word at 4.
        m_if.start = 1'b1;
        push_main(32'd0);
        tick();
        m_if.start = 1'b0;
        check("init_mem_init_e0", 32'(m_if.mem_init), 32'd1);
        tick();
        check("init_mem_init_e1", 32'(m_if.mem_init), 32'd1);
        tick();
        check("init_mem_init_e2", 32'(m_if.mem_init), 32'd0);
        check("init_no_valid_yet", 32'(m_if.instr_valid), 32'd0);
        tick();
        check("first_valid", 32'(m_if.instr_valid), 32'd1);
        tick();
        check("conv_wait_set",   32'(m_if.conv_wait),   32'd1);
        check("conv_valid_low",  32'(m_if.instr_valid), 32'd0);
        check("conv_mem_pc",     m_if.mem_pc,           32'd4);
        tick();
        check("conv_wait_held",  32'(m_if.conv_wait),   32'd1);
        m_if.conv_done = 1'b1;
        push_main(32'd4);
        tick();
        m_if.conv_done = 1'b0;
        check("conv_wait_clear", 32'(m_if.conv_wait),   32'd0);
        tick();
        check("after_conv_valid", 32'(m_if.instr_valid), 32'd1);
        push_main(32'd8);
        push_main(32'd12);

        // Backpressure on the word at 8.
        tick();
        m_if.instr_ready = 1'b0;
        check("bp_instr_pc", m_if.instr_pc, 32'd8);
        check("bp_instr",    m_if.instr,    32'h035A02B3);
        check("bp_mem_pc",   m_if.mem_pc,   32'd12);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_hold_instr_pc", m_if.instr_pc,           32'd8);
            check("bp_hold_instr",    m_if.instr,              32'h035A02B3);
            check("bp_hold_mem_pc",   m_if.mem_pc,             32'd12);
            check("bp_hold_valid",    32'(m_if.instr_valid),   32'd1);
        end
        m_if.instr_ready = 1'b1;
        tick();
        check("bp_release_pc", m_if.instr_pc, 32'd12);

        // Redirect back to 8 while 12 is accepted.
        m_if.redirect    = 1'b1;
        m_if.redirect_pc = 32'd8;
        tick();
        m_if.redirect = 1'b0;
        check("redir8_valid_low", 32'(m_if.instr_valid), 32'd0);
        check("redir8_mem_pc",    m_if.mem_pc,           32'd8);
        push_main(32'd8);
        tick();

        // Redirect to 0x15 while 8 is accepted: 12 must never appear.
        m_if.redirect    = 1'b1;
        m_if.redirect_pc = 32'h15;
        push_main(32'd20);
        push_main(32'd24);
        push_main(32'd28);
        tick();
        m_if.redirect = 1'b0;
        check("redir15_mem_pc", m_if.mem_pc, 32'd20);
        repeat (3) tick();
        check("end_last_mem_pc", m_if.mem_pc, 32'd28);
        tick();
        check("end_halted",   32'(m_if.halted),      32'd1);
        check("end_valid",    32'(m_if.instr_valid), 32'd0);
        check("end_mem_pc",   m_if.mem_pc,           32'd28);
        check("end_queue",    32'(mq.size()),        32'd0);
        tick();
        check("halt_held",    32'(m_if.halted),      32'd1);

        // Restart from HALT, then redirect and conv_done together.
        m_if.start = 1'b1;
        push_main(32'd0);
        tick();
        m_if.start = 1'b0;
        check("restart_halted",   32'(m_if.halted),   32'd0);
        check("restart_mem_init", 32'(m_if.mem_init), 32'd1);
        check("restart_mem_pc",   m_if.mem_pc,        32'd0);
        repeat (4) tick();
        check("sim_conv_wait", 32'(m_if.conv_wait), 32'd1);
        m_if.redirect    = 1'b1;
        m_if.redirect_pc = 32'd16;
        m_if.conv_done   = 1'b1;
        push_main(32'd16);
        tick();
        m_if.redirect  = 1'b0;
        m_if.conv_done = 1'b0;
        check("sim_conv_clear", 32'(m_if.conv_wait),   32'd0);
        check("sim_mem_pc",     m_if.mem_pc,           32'd16);
        check("sim_valid_low",  32'(m_if.instr_valid), 32'd0);
        tick();
        check("sim_instr_pc",   m_if.instr_pc,         32'd16);
        check("sim_valid",      32'(m_if.instr_valid), 32'd1);

        // Asynchronous reset between edges while 16 is valid.
        #5;
        reset = 1'b0;
        #1;
        check_reset_state("async_rst");
        tick();
        reset = 1'b1;
        tick();
        m_if.start = 1'b1;
        push_main(32'd0);
        tick();
        m_if.start = 1'b0;
        check("rr_mem_init_e0", 32'(m_if.mem_init), 32'd1);
        tick();
        check("rr_mem_init_e1", 32'(m_if.mem_init), 32'd1);
        tick();
        check("rr_mem_init_e2", 32'(m_if.mem_init), 32'd0);
        tick();
        check("rr_first_pc",    m_if.instr_pc,      32'd0);

        // Out-of-range redirect while the custom word is accepted.
        m_if.redirect    = 1'b1;
        m_if.redirect_pc = 32'h40;
        tick();
        m_if.redirect = 1'b0;
        check("oob_halted",    32'(m_if.halted),      32'd1);
        check("oob_conv_wait", 32'(m_if.conv_wait),   32'd0);
        check("oob_valid",     32'(m_if.instr_valid), 32'd0);
        check("oob_queue",     32'(mq.size()),        32'd0);

        // WRAP=1 instance: full pass, 28 -> 0 back to back.
        for (int i = 0; i < 8; i++) wq.push_back(mk(32'(i * 4)));
        wq.push_back(mk(32'd0));
        wq.push_back(mk(32'd4));
        w_if.start = 1'b1;
        tick();
        w_if.start = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (wq.size() == 0) break;
            tick();
        end
        w_if.instr_ready = 1'b0;
        check("wrap_queue_drained", 32'(wq.size()), 32'd0);
        tick();
        w_if.redirect    = 1'b1;
        w_if.redirect_pc = 32'h40;
        tick();
        w_if.redirect = 1'b0;
        check("wrap_oob_halted", 32'(w_if.halted), 32'd1);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/inst_fetch_ctrl.md
# inst_fetch_ctrl

Fetch sequencer for the 32-byte instruction memory. Drives the memory's init strobe and byte-address PC, and registers each returned 32-bit instruction code into a valid/ready output stage toward decode. Supports branch redirects and ends cleanly at the end of the program. Stalls fetch while a custom-0 convolution instruction (opcode 7'b0001011) is executing, until the execute stage signals completion.

## Interface
- MEM_BYTES, 32, instruction memory size in bytes; multiple of 4.
- INIT_CYCLES, 2, number of cycles mem_init is held high; ≥1.
- WRAP, 0, 1 = PC wraps to 0 after the last word; 0 = halt after the last word.
- CUSTOM_OPCODE, 7'b0001011, opcode that triggers the convolution wait.
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low; 0 = reset asserted.
- start  in  1  level; sampled in IDLE/HALT to begin (re)initialisation.
- mem_init  out  1  active-high init strobe to instruction memory.
- mem_pc  out  32  byte address to instruction memory; always word aligned.
- mem_instr  in  32  instruction code returned combinationally for mem_pc.
- instr  out  32  registered instruction to decode.
- instr_pc  out  32  byte address of instr.
- instr_valid  out  1  instr/instr_pc valid.
- instr_ready  in  1  decode accepts the instruction when instr_valid&instr_ready.
- redirect  in  1  one-cycle branch/jump request.
- redirect_pc  in  32  redirect target; bits [1:0] are ignored.
- conv_done  in  1  execute reports the convolution instruction has completed.
- conv_wait  out  1  high while in CONV_WAIT.
- halted  out  1  high in HALT.

## Operation
- States: IDLE, INIT, FETCH, CONV_WAIT, HALT. Reset enters IDLE.
- **IDLE**
  - start=1 → INIT.
  - Load the counter with INIT_CYCLES.
  - mem_pc<=0.
- **INIT**
  - mem_init=1.
  - Decrement the counter each cycle; when it reaches 1 → FETCH.
  - redirect is ignored.
- **FETCH** (load condition: instr_valid=0, or instr_valid&instr_ready)
  - On a load: instr<=mem_instr, instr_pc<=mem_pc, instr_valid<=1, mem_pc<=next.
  - Without a load: hold all outputs; mem_pc is stable.
  - next = mem_pc+4, except when mem_pc==MEM_BYTES-4:
    - WRAP=1: next=0.
    - WRAP=0: set the internal last flag; no further loads occur.
  - Accept of an instruction with last flag set (WRAP=0) → HALT; instr_valid<=0.
  - Accept of an instruction with instr[6:0]==CUSTOM_OPCODE → CONV_WAIT; instr_valid<=0; no load that cycle.
- **CONV_WAIT**
  - instr_valid=0 and conv_wait=1.
  - conv_done=1 → FETCH; mem_pc is unchanged, already pointing at the next word.
  - If the convolution instruction was the last word and WRAP=0, conv_done → HALT.
- **Redirect** (valid in FETCH or CONV_WAIT; highest priority, beats an accept, conv_done or load in the same cycle)
  - instr_valid<=0; the instruction being accepted that cycle is still counted as accepted.
  - last flag cleared; state → FETCH.
  - mem_pc<={redirect_pc[31:2],2'b00}.
  - redirect_pc ≥ MEM_BYTES → HALT instead.
- **HALT**
  - halted=1 and instr_valid=0.
  - start=1 → INIT; PC restarts at 0 and mem_init re-pulses.
- **Widths:** mem_pc and instr_pc are 32-bit. All compares are unsigned against MEM_BYTES.

## Timing
- **Reset values:**
  - mem_init=0, mem_pc=0.
  - instr=0, instr_pc=0, instr_valid=0.
  - conv_wait=0, halted=0.
- **Reset mid-operation:** all outputs go to their reset values immediately, without waiting for clk; the state becomes IDLE.
- **Start to first instruction:**
  - start sampled at edge E0.
  - mem_init high from E0 to E0+INIT_CYCLES.
  - FETCH entered at E0+INIT_CYCLES.
  - First instr_valid=1 at E0+INIT_CYCLES+1.
- **Throughput:** one instruction per cycle while instr_ready=1.
- **Backpressure:**
  - instr_ready=0 holds instr, instr_pc, instr_valid and mem_pc unchanged.
  - instr_valid never drops without an accept, redirect or reset.
- **Redirect latency:** redirect at edge E gives the target instruction valid at E+1.
- **Convolution wait:**
  - The accept edge of the custom-0 instruction enters CONV_WAIT.
  - conv_done at edge E gives the next instruction valid at E+1.
  - conv_done outside CONV_WAIT is ignored.

## Test plan
- **Default program:** INIT_CYCLES=2, memory loaded with 0x010C0E0B at 0, 0x413903B3 at 4, instr_ready=1, start pulse.
  - Required: mem_init high for 2 cycles, then instr=0x010C0E0B with instr_pc=0.
  - Then CONV_WAIT with conv_wait=1.
  - conv_done → next cycle instr=0x413903B3 with instr_pc=4.
- **End of program:** WRAP=0, run all 8 words (conv_done asserted as needed).
  - Required: after the word at instr_pc=28 is accepted, halted=1, instr_valid=0, mem_pc=28.
  - WRAP=1: instr_pc=0 follows instr_pc=28 with no gap.
- **Backpressure:** instr_ready=0 for 3 cycles while instr_pc=8.
  - Required: instr=0x035A02B3 and instr_pc=8 held stable, mem_pc=12 held.
  - On release: instr_pc=12 the next cycle.
- **Redirect:** redirect=1, redirect_pc=0x15 while instr_pc=8 is valid and being accepted.
  - Required: the next instr_pc=20 and the word at 12 is never presented.
  - Separate case: redirect_pc=0x40 → halted=1.
- **Simultaneous events:** redirect (target 16) and conv_done together in CONV_WAIT → FETCH, next instr_pc=16.
- **Reset mid-operation:** reset=0 asynchronously while instr_pc=16 is valid.
  - Required: all outputs are at their reset values before the next clk edge.
  - Then start → the sequence restarts from instr_pc=0 after the mem_init pulse.
